// File: rtl/pcie_phy_pkg.sv
// rtl/pcie_phy_pkg.sv - shared PIPE PHY model types and constants
package pcie_phy_pkg;

    typedef enum logic [2:0] {
        ST_RESET_HOLD,
        ST_IDLE,
        ST_DETECT,
        ST_PD_CHANGE,
        ST_RATE_CHANGE
    } phy_state_t;

    localparam logic [1:0] PIPE_PD_P1           = 2'b10;
    localparam logic [2:0] RXSTATUS_RX_DETECTED = 3'b011;

endpackage

// File: rtl/pipe_phy_responder.sv
// rtl/pipe_phy_responder.sv - behavioural PIPE PHY handshake responder (PhyStatus/RxStatus)
module pipe_phy_responder
    import pcie_phy_pkg::*;
#(
    parameter int MAX_NUM_LANES = 1,
    parameter int RESET_CYCLES  = 64,
    parameter int DETECT_CYCLES = 32,
    parameter int PD_CYCLES     = 8,
    parameter int RATE_CYCLES   = 16
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       phy_txdetectrx,
    input  logic [1:0]                 phy_powerdown,
    input  logic [2:0]                 phy_rate,
    input  logic [MAX_NUM_LANES-1:0]   rx_present_i,
    output logic [MAX_NUM_LANES-1:0]   phy_phystatus,
    output logic                       phy_phystatus_rst,
    output logic [MAX_NUM_LANES*3-1:0] phy_rxstatus,
    output logic                       busy_o
);

    phy_state_t                 state;
    phy_state_t                 start_state;
    logic [15:0]                cnt;
    logic [15:0]                start_cnt;
    logic [1:0]                 ack_pd;
    logic [1:0]                 tgt_pd;
    logic [2:0]                 ack_rate;
    logic [2:0]                 tgt_rate;
    logic                       detect_done;
    logic                       det_req;
    logic                       pd_req;
    logic                       rate_req;
    logic [MAX_NUM_LANES*3-1:0] det_rx;

    assign det_req  = phy_txdetectrx && (phy_powerdown == PIPE_PD_P1) && !detect_done;
    assign pd_req   = (phy_powerdown != ack_pd);
    assign rate_req = (phy_rate != ack_rate);

    always_comb begin
        det_rx = '0;
        for (int i = 0; i < MAX_NUM_LANES; i++) begin
            if (rx_present_i[i]) begin
                det_rx[i*3 +: 3] = RXSTATUS_RX_DETECTED;
            end
        end
    end

    // Request arbitration in IDLE: detect beats powerdown beats rate; the counter
    // is loaded with L-1 so the PhyStatus pulse lands on the L-th busy cycle.
    always_comb begin
        start_state = ST_IDLE;
        start_cnt   = '0;
        if (det_req) begin
            start_state = ST_DETECT;
            start_cnt   = 16'(DETECT_CYCLES - 1);
        end else if (pd_req) begin
            start_state = ST_PD_CHANGE;
            start_cnt   = 16'(PD_CYCLES - 1);
        end else if (rate_req) begin
            start_state = ST_RATE_CHANGE;
            start_cnt   = 16'(RATE_CYCLES - 1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= ST_RESET_HOLD;
            cnt               <= 16'(RESET_CYCLES - 1);
            phy_phystatus     <= '1;
            phy_phystatus_rst <= 1'b1;
            phy_rxstatus      <= '0;
            busy_o            <= 1'b1;
            detect_done       <= 1'b0;
            ack_pd            <= '0;
            ack_rate          <= '0;
            tgt_pd            <= '0;
            tgt_rate          <= '0;
        end else begin
            case (state)
                ST_RESET_HOLD: begin
                    ack_pd   <= phy_powerdown;
                    ack_rate <= phy_rate;
                    if (cnt == 16'd0) begin
                        state             <= ST_IDLE;
                        phy_phystatus     <= '0;
                        phy_phystatus_rst <= 1'b0;
                        busy_o            <= 1'b0;
                    end else begin
                        cnt <= cnt - 16'd1;
                    end
                end
                ST_IDLE: begin
                    if (start_state != ST_IDLE) begin
                        state    <= start_state;
                        cnt      <= start_cnt;
                        busy_o   <= 1'b1;
                        tgt_pd   <= phy_powerdown;
                        tgt_rate <= phy_rate;
                        if (start_cnt == 16'd0) begin
                            phy_phystatus <= '1;
                            if (start_state == ST_DETECT) begin
                                phy_rxstatus <= det_rx;
                            end
                        end
                    end
                end
                default: begin
                    if (cnt == 16'd0) begin
                        state         <= ST_IDLE;
                        busy_o        <= 1'b0;
                        phy_phystatus <= '0;
                        phy_rxstatus  <= '0;
                        if (state == ST_DETECT) begin
                            detect_done <= 1'b1;
                        end
                        if (state == ST_PD_CHANGE) begin
                            ack_pd <= tgt_pd;
                        end
                        if (state == ST_RATE_CHANGE) begin
                            ack_rate <= tgt_rate;
                        end
                    end else begin
                        cnt <= cnt - 16'd1;
                        if (cnt == 16'd1) begin
                            phy_phystatus <= '1;
                            if (state == ST_DETECT) begin
                                phy_rxstatus <= det_rx;
                            end
                        end
                    end
                end
            endcase
            if (!phy_txdetectrx) begin
                detect_done <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pipe_phy_responder.sv
// tb/tb_pipe_phy_responder.sv - scoreboard bench for pipe_phy_responder
module tb_pipe_phy_responder;

    localparam int LANES = 4;

    typedef struct {
        int          cyc;
        logic [11:0] rx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             txdet = 1'b0;
    logic [1:0]       pd = 2'b00;
    logic [2:0]       rate = 3'd0;
    logic [LANES-1:0] rx_present = 4'b0101;
    logic [LANES-1:0] phystatus;
    logic             phystatus_rst;
    logic [11:0]      rxstatus;
    logic             busy;

    int   cyc = 0;
    int   compared = 0;
    int   mismatched = 0;
    exp_t sb[$];

    pipe_phy_responder #(
        .MAX_NUM_LANES(LANES),
        .RESET_CYCLES (64),
        .DETECT_CYCLES(32),
        .PD_CYCLES    (8),
        .RATE_CYCLES  (16)
    ) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .phy_txdetectrx   (txdet),
        .phy_powerdown    (pd),
        .phy_rate         (rate),
        .rx_present_i     (rx_present),
        .phy_phystatus    (phystatus),
        .phy_phystatus_rst(phystatus_rst),
        .phy_rxstatus     (rxstatus),
        .busy_o           (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every PhyStatus/RxStatus activity outside reset must match the next scoreboard entry.
    always @(negedge clk) begin
        if (!rst && !phystatus_rst && (phystatus != 4'h0 || rxstatus != 12'h0)) begin
            if (sb.size() == 0) begin
                compared++;
                assert ({phystatus, rxstatus} === 16'h0)
                else begin
                    mismatched++;
                    $error("FAIL unexpected_pulse cyc=%0d observed=%h expected=0000", cyc, {phystatus, rxstatus});
                end
            end else begin
                exp_t e;
                e = sb.pop_front();
                compared++;
                assert (cyc === e.cyc)
                else begin
                    mismatched++;
                    $error("FAIL pulse_cycle observed=%0d expected=%0d", cyc, e.cyc);
                end
                compared++;
                assert (phystatus === 4'hF)
                else begin
                    mismatched++;
                    $error("FAIL pulse_lanes observed=%h expected=f", phystatus);
                end
                compared++;
                assert (rxstatus === e.rx)
                else begin
                    mismatched++;
                    $error("FAIL rxstatus observed=%b expected=%b", rxstatus, e.rx);
                end
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_pulse(input int at, input logic [11:0] rx);
        exp_t e;
        e.cyc = at;
        e.rx  = rx;
        sb.push_back(e);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Call just after a posedge with rst just dropped: counts reset-hold cycles.
    task automatic check_reset_hold(input string tag);
        int n;
        int hold_bad;
        n = 0;
        hold_bad = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!phystatus_rst) break;
            n++;
            if (phystatus !== 4'hF || busy !== 1'b1) hold_bad++;
        end
        check({tag, "_len"}, n, 64);
        check({tag, "_hold_outputs"}, hold_bad, 0);
        check({tag, "_busy_fall"}, {31'd0, busy}, 0);
        check({tag, "_phystatus_fall"}, {28'd0, phystatus}, 0);
        step(1);
    endtask

    task automatic drain(input string tag, input int n);
        step(n);
        check({tag, "_drained"}, sb.size(), 0);
        check({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    initial begin
        int n;
        int busy_seen;

        step(3);
        @(negedge clk);
        check("reset_phystatus", {28'd0, phystatus}, 32'hF);
        check("reset_phystatus_rst", {31'd0, phystatus_rst}, 1);
        check("reset_rxstatus", {20'd0, rxstatus}, 0);
        check("reset_busy", {31'd0, busy}, 1);
        step(1);
        rst = 1'b0;
        check_reset_hold("hold1");

        // Enter P1 so detect can be exercised.
        n = cyc;
        pd = 2'b10;
        expect_pulse(n + 8, 12'h000);
        drain("pd_p1", 12);

        // Receiver detect, held request must not retrigger.
        n = cyc;
        txdet = 1'b1;
        expect_pulse(n + 32, 12'b000_011_000_011);
        drain("detect", 100);
        txdet = 1'b0;
        step(2);

        // Back to P0, then detect request outside P1 is ignored.
        n = cyc;
        pd = 2'b00;
        expect_pulse(n + 8, 12'h000);
        drain("pd_p0", 12);
        txdet = 1'b1;
        busy_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy) busy_seen++;
        end
        check("detect_ignored_busy", busy_seen, 0);
        check("detect_ignored_queue", sb.size(), 0);
        step(1);
        txdet = 1'b0;
        step(2);

        // Simultaneous powerdown and rate change.
        n = cyc;
        pd = 2'b10;
        rate = 3'd1;
        expect_pulse(n + 8, 12'h000);
        expect_pulse(n + 25, 12'h000);
        drain("pd_rate", 40);

        // Rate back to 0, then a change during the busy window.
        n = cyc;
        rate = 3'd0;
        expect_pulse(n + 16, 12'h000);
        drain("rate0", 20);
        n = cyc;
        rate = 3'd1;
        step(5);
        rate = 3'd2;
        expect_pulse(n + 16, 12'h000);
        expect_pulse(n + 33, 12'h000);
        drain("rate_twice", 60);

        // Reset mid-detect abandons the operation.
        txdet = 1'b1;
        step(10);
        rst = 1'b1;
        txdet = 1'b0;
        @(negedge clk);
        check("midreset_busy", {31'd0, busy}, 1);
        check("midreset_phystatus_rst", {31'd0, phystatus_rst}, 1);
        step(1);
        rst = 1'b0;
        check_reset_hold("hold2");
        drain("after_reset", 100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
